mul_sched: RTL and testbench

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched_pkg.sv | 19 +
 rtl/mul_sched_if.sv | 34 +++
 rtl/mul_sched_tag_fifo.sv | 59 +++++
 rtl/mul_sched.sv | 122 ++++++++++++
 tb/tb_mul_sched.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier job scheduler.
package mul_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_ISSUE     = 3'b010,
    ST_SLOT_WAIT = 3'b100
  } state_e;

  function automatic logic [NREQ-1:0] id_to_onehot(input logic id);
    logic [NREQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Requester, pipeline and response signals of the multiplier scheduler.
interface mul_sched_if #(
  parameter int N = 512
);
  import mul_sched_pkg::*;

  localparam int LOGN = $clog2(N);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][N-1:0]   req_a;
  logic [NREQ-1:0][N-1:0]   req_b;
  logic [NREQ-1:0][LOGN:0]  req_k;
  logic                     mul_start;
  logic [N-1:0]             mul_a;
  logic [N-1:0]             mul_b;
  logic [LOGN:0]            mul_k;
  logic                     mul_done;
  logic [N-1:0]             mul_res;
  logic [NREQ-1:0]          rsp_valid;
  logic [N-1:0]             rsp_data;
  logic                     err;

  modport slave (
    input  req_valid, req_a, req_b, req_k, mul_done, mul_res,
    output req_ready, mul_start, mul_a, mul_b, mul_k, rsp_valid, rsp_data, err
  );

  modport master (
    output req_valid, req_a, req_b, req_k, mul_done, mul_res,
    input  req_ready, mul_start, mul_a, mul_b, mul_k, rsp_valid, rsp_data, err
  );

endinterface

// File: rtl/mul_sched_tag_fifo.sv
// Small FIFO remembering which requester owns each job in flight.
module tag_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Two-requester round-robin scheduler feeding a fixed-interval multiplier pipeline.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int N           = 512,
  parameter int N_CYCLES    = N + 1,
  parameter int PIPE_STAGES = 3
) (
  input  logic       clock,
  input  logic       reset,
  mul_sched_if.slave bus
);

  localparam int LOGN = $clog2(N);
  localparam int LOGC = $clog2(N_CYCLES);

  state_e          state_q, state_d;
  logic [LOGC-1:0] slot_q, slot_d;
  logic            last_grant_q;
  logic [N-1:0]    mul_a_q, mul_b_q;
  logic [LOGN:0]   mul_k_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [N-1:0]    rsp_data_q;
  logic            err_q;

  logic grant, accept, pop, pop_id, fifo_full, fifo_empty;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    if (&bus.req_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req_valid[1];
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid && !fifo_full) begin
          bus.req_ready = id_to_onehot(grant);
          accept        = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.mul_start = 1'b1;
        slot_d        = LOGC'(N_CYCLES - 2);
        state_d       = ST_SLOT_WAIT;
      end
      ST_SLOT_WAIT: begin
        slot_d = slot_q - LOGC'(1);
        if (slot_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = bus.mul_done && !fifo_empty;

  tag_fifo #(
    .DEPTH (PIPE_STAGES),
    .WIDTH (1)
  ) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .din   (grant),
    .pop   (pop),
    .dout  (pop_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      last_grant_q <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_k_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      rsp_valid_q <= '0;
      if (accept) begin
        last_grant_q <= grant;
        mul_a_q      <= bus.req_a[grant];
        mul_b_q      <= bus.req_b[grant];
        mul_k_q      <= bus.req_k[grant];
      end
      // A result with no owner is dropped and latched as an error.
      if (bus.mul_done) begin
        if (fifo_empty) begin
          err_q <= 1'b1;
        end else begin
          rsp_valid_q <= id_to_onehot(pop_id);
          rsp_data_q  <= bus.mul_res;
        end
      end
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_k     = mul_k_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mul_sched.sv
// Randomized bench for mul_sched against a queue-based behavioural model.
module tb_mul_sched;
  import mul_sched_pkg::*;

  localparam int N   = 8;
  localparam int NC  = 9;
  localparam int PS  = 3;
  localparam int LAT = 27;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sched_if #(.N(N)) bus ();

  mul_sched #(
    .N           (N),
    .N_CYCLES    (NC),
    .PIPE_STAGES (PS)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int           due;
    logic [N-1:0] res;
  } pipe_t;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  // Reference model state
  int           next_ok;
  int           start_cyc;
  bit           last_grant;
  bit           tagq[$];
  pipe_t        pipeq[$];
  bit           rsp_pend;
  bit           rsp_id;
  logic [N-1:0] exp_rsp_data, exp_a, exp_b;
  logic [3:0]   exp_k;
  bit           exp_err;
  // Stimulus controls
  int           vmode;
  bit           pipe_on, inject_done, fixed_ops, rst_req;
  int           acc_cyc_last = -100;
  int           first_rsp_cyc;
  logic [N-1:0] first_rsp_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    next_ok      = 0;
    start_cyc    = -1;
    last_grant   = 1'b1;
    tagq.delete();
    pipeq.delete();
    rsp_pend     = 1'b0;
    rsp_id       = 1'b0;
    exp_rsp_data = '0;
    exp_a        = '0;
    exp_b        = '0;
    exp_k        = '0;
    exp_err      = 1'b0;
  endtask

  task automatic do_cycle();
    logic [1:0] v;
    logic [1:0] r_exp;
    bit         g;
    @(posedge clk);
    cyc++;
    #1;
    rst = rst_req;
    case (vmode)
      0:       v = 2'b00;
      1:       v = 2'b11;
      2:       v = 2'b10;
      3:       v = 2'b01;
      default: v = 2'($urandom);
    endcase
    bus.req_valid = v;
    for (int r = 0; r < 2; r++) begin
      bus.req_a[r] = N'($urandom);
      bus.req_b[r] = N'($urandom);
      bus.req_k[r] = 4'($urandom);
    end
    if (fixed_ops) begin
      bus.req_a[0] = 8'd3;
      bus.req_b[0] = 8'd5;
      bus.req_k[0] = 4'd8;
    end
    bus.mul_done = 1'b0;
    bus.mul_res  = N'($urandom);
    if (pipeq.size() > 0 && pipeq[0].due == cyc) begin
      bus.mul_done = 1'b1;
      bus.mul_res  = pipeq[0].res;
      pipeq.delete(0);
    end
    if (inject_done) begin
      bus.mul_done = 1'b1;
      inject_done  = 1'b0;
    end

    @(negedge clk);
    if (rst) begin
      model_reset();
      return;
    end

    r_exp = 2'b00;
    g     = 1'b0;
    if (cyc >= next_ok && tagq.size() < PS && v != 2'b00) begin
      g     = (v == 2'b11) ? ~last_grant : v[1];
      r_exp = 2'b01 << g;
    end
    chk("req_ready", bus.req_ready, r_exp);
    chk("mul_start", bus.mul_start, cyc == start_cyc);
    chk("mul_a", bus.mul_a, exp_a);
    chk("mul_b", bus.mul_b, exp_b);
    chk("mul_k", bus.mul_k, exp_k);
    chk("rsp_valid", bus.rsp_valid, rsp_pend ? (2'b01 << rsp_id) : 2'b00);
    chk("rsp_data", bus.rsp_data, exp_rsp_data);
    chk("err", bus.err, exp_err);

    if (bus.rsp_valid != 2'b00) begin
      $display("cycle %0d: response rsp_valid=%b data=%0d", cyc, bus.rsp_valid, bus.rsp_data);
      if (first_rsp_cyc < 0) begin
        first_rsp_cyc  = cyc;
        first_rsp_data = bus.rsp_data;
      end
    end
    if (bus.mul_start && pipe_on) begin
      pipeq.push_back('{cyc + LAT, N'(bus.mul_a * bus.mul_b)});
    end

    // Effects of the upcoming edge: pop before push, ready from current occupancy.
    rsp_pend = 1'b0;
    if (bus.mul_done) begin
      if (tagq.size() > 0) begin
        rsp_pend     = 1'b1;
        rsp_id       = tagq[0];
        exp_rsp_data = bus.mul_res;
        tagq.delete(0);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (r_exp != 2'b00) begin
      next_ok      = cyc + NC;
      start_cyc    = cyc + 1;
      last_grant   = g;
      exp_a        = bus.req_a[g];
      exp_b        = bus.req_b[g];
      exp_k        = bus.req_k[g];
      tagq.push_back(g);
      acc_cyc_last = cyc;
      $display("cycle %0d: accept req%0d a=%0d b=%0d k=%0d", cyc, g, exp_a, exp_b, exp_k);
    end
  endtask

  initial begin
    int acc0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_k     = '0;
    bus.mul_done  = 1'b0;
    bus.mul_res   = '0;
    model_reset();
    rst_req     = 1'b1;
    vmode       = 0;
    pipe_on     = 1'b1;
    inject_done = 1'b0;
    fixed_ops   = 1'b0;
    first_rsp_cyc = -1;
    repeat (3) do_cycle();
    rst_req = 1'b0;
    repeat (2) do_cycle();

    // Single job from requester 0: 3*5 back 29 cycles after accept.
    fixed_ops     = 1'b1;
    vmode         = 3;
    first_rsp_cyc = -1;
    do_cycle();
    acc0      = acc_cyc_last;
    fixed_ops = 1'b0;
    vmode     = 0;
    repeat (35) do_cycle();
    chk("single_latency", 64'(first_rsp_cyc - acc0), 64'd29);
    chk("single_data", first_rsp_data, 8'd15);

    // Both requesters continuously valid: alternation, full FIFO, pop/accept overlap.
    vmode = 1;
    repeat (90) do_cycle();
    vmode = 0;
    repeat (35) do_cycle();

    // Requester 1 only with a stalled pipeline: three jobs then back-pressure.
    pipe_on = 1'b0;
    vmode   = 2;
    repeat (40) do_cycle();
    inject_done = 1'b1;
    repeat (13) do_cycle();
    vmode = 0;
    repeat (3) begin
      inject_done = 1'b1;
      repeat (3) do_cycle();
    end
    pipe_on = 1'b1;

    // Result with nothing in flight sets the sticky error.
    inject_done = 1'b1;
    repeat (6) do_cycle();
    vmode = 4;
    repeat (60) do_cycle();
    vmode = 0;
    repeat (35) do_cycle();

    // Reset four cycles after a mul_start, with a stray result during reset.
    vmode = 3;
    do_cycle();
    vmode = 0;
    repeat (4) do_cycle();
    rst_req     = 1'b1;
    inject_done = 1'b1;
    do_cycle();
    rst_req = 1'b0;
    repeat (40) do_cycle();

    // Random traffic.
    vmode = 4;
    repeat (150) do_cycle();
    vmode = 0;
    repeat (35) do_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
